conv3x3_stream: RTL and testbench
=================================

Name: conv3x3_stream

Overview:
- Streaming 3x3 convolution engine for raster-order pixels. It is the parametrised successor to the fixed single-window sharpening block.
- Two internal line buffers build the 3x3 window on the fly. The nine coefficients are runtime-loadable, and the result passes through a 3-stage valid/ready pipeline.
- Each output has an arithmetic right shift, then a clamp to pixel range.
- Sits between the pixel source (frame reader) and downstream filters/writer, and serves sharpen, blur and edge kernels without RTL change.

Parameters:
- PIX_W, 8, unsigned pixel width.
- COEF_W, 8, signed coefficient width.
- IMG_W, 640, pixels per line (>= 3).
- SHIFT, 0, arithmetic right shift applied to the accumulator before clamping.
- ACC_W, PIX_W+COEF_W+5, accumulator width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  4  coefficient index 0..8, row-major (0 = top-left, 4 = centre); 9..15 ignored.
- coef_data  in  COEF_W  signed coefficient value.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  engine accepts in_pix this cycle.
- in_sof  in  1  qualifies in_pix as pixel (row 0, col 0) of a frame.
- in_pix  in  PIX_W  input pixel, raster order.
- out_valid  out  1  output result valid.
- out_ready  in  1  downstream accepts the result.
- out_raw  out  ACC_W  signed value acc >>> SHIFT, unclamped.
- out_pix  out  PIX_W  out_raw clamped to [0, 2^PIX_W-1].

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_raw=0, out_pix=0.
  - Column and row counters = 0; all pipeline valid bits cleared.
  - Coefficients = identity kernel (index 4 = 1, all others 0).
  - Line-buffer contents are not cleared.
  - in_ready=0 while rst is high.
  - Reset mid-frame discards all in-flight results; the next frame must start with in_sof.
- Handshake:
  - advance = out_ready | ~out_valid; in_ready = advance & ~rst.
  - Input accepted when in_valid & in_ready.
  - All pipeline stages move only on advance; bubbles propagate as valid=0.
  - While out_valid=1 and out_ready=0, out_raw/out_pix/out_valid hold stable.
- Counters (update on accept):
  - in_sof=1 forces this pixel to col=0, row=0.
  - Otherwise col increments; at col=IMG_W-1 it wraps to 0 and row increments.
  - row saturates at 2 (only "row>=2" is needed).
  - in_sof mid-line is legal and restarts the frame; partially filled lines are discarded.
- Window: on accept, each row's 3-tap shift register shifts in: top row from line buffer 2, middle row from line buffer 1, bottom row from in_pix. The line buffers are written in the same cycle (delay IMG_W each).
- Window validity: the window is valid when accepted pixel has row>=2 and col>=2. The result then corresponds to centre pixel (row-1, col-1). Output image is (IMG_W-2) x (H-2); no border padding. Windows spanning a line wrap are never valid.
- Pipeline, latency 3 advancing cycles from accept to out_valid:
  - S1: nine products, pixel zero-extended to signed PIX_W+1, times signed coefficient.
  - S2: signed adder tree to ACC_W.
  - S3: arithmetic shift by SHIFT, clamp, register outputs.
- Arithmetic rules: ACC_W holds the worst case; no internal overflow. Clamp: out_raw<0 -> out_pix=0; out_raw>2^PIX_W-1 -> out_pix=2^PIX_W-1; otherwise out_pix=out_raw[PIX_W-1:0].
- Coefficients:
  - Write at edge t is used by S1 computations from edge t+1 onward. Results already past S1 keep the old coefficients.
  - coef_we is independent of the stream. Simultaneous write and accept is legal.
  - Writes with addr >= 9 have no effect.
- Throughput: 1 result per cycle under continuous valid with out_ready=1.

Test Plan:
- Identity after reset, IMG_W=4, 4x4 frame of values 1..16: exactly 4 outputs in order 6,7,10,11; out_raw equals out_pix; first out_valid 3 cycles after accepting pixel (2,2).
- Sharpen kernel {0,-1,0,-1,5,-1,0,-1,0}, IMG_W=3, rows {2,0,0},{5,255,0},{1,2,4}: single output with out_raw=1268, out_pix=255.
- Negative clamp: same kernel, rows {255,255,255},{255,0,255},{255,255,255}: out_raw=-1020, out_pix=0.
- Backpressure: random out_ready (50% duty) over a 4x4 frame: output sequence identical to the no-stall run; outputs stable while stalled; no accept while in_ready=0.
- SHIFT=4, all-ones kernel, constant frame 16: out_raw=9, out_pix=9. Coefficient rewrite between frames takes effect on the next frame only.
- Mid-frame in_sof after 6 pixels, then a full 4x4 frame: no output from the aborted part; new frame yields exactly 4 correct outputs.
- Mid-frame reset: rst for 1 cycle with results in flight clears out_valid next edge; frame then restarted with in_sof gives correct results.

Source files
------------

// File: rtl/conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : conv3x3_stream
// Purpose  : Streaming 3x3 convolution over raster-order pixels. Two line
//            buffers plus three 3-tap shift registers form the window; nine
//            runtime-loadable signed coefficients feed a 3-stage
//            valid/ready pipeline (multiply, adder tree, shift + clamp).
// Ports    : clk, rst               - clock, synchronous active-high reset
//            coef_we/addr/data      - coefficient write port (addr 0..8,
//                                     row-major, 4 = centre)
//            in_valid/in_ready      - input handshake
//            in_sof, in_pix         - start-of-frame flag and pixel
//            out_valid/out_ready    - output handshake
//            out_raw                - signed acc >>> SHIFT, unclamped
//            out_pix                - out_raw clamped to pixel range
// Revision : 1.0 - initial release
// ============================================================================
module conv3x3_stream #(
    parameter int PIX_W  = 8,
    parameter int COEF_W = 8,
    parameter int IMG_W  = 640,
    parameter int SHIFT  = 0,
    parameter int ACC_W  = PIX_W + COEF_W + 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              coef_we,
    input  logic [3:0]        coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sof,
    input  logic [PIX_W-1:0]  in_pix,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_raw,
    output logic [PIX_W-1:0]  out_pix
);

    localparam int                      c_prod_w   = PIX_W + COEF_W + 1;
    localparam int                      c_cnt_w    = $clog2(IMG_W);
    localparam logic [c_cnt_w-1:0]      c_col_last = c_cnt_w'(IMG_W - 1);
    localparam logic [c_cnt_w-1:0]      c_col_two  = c_cnt_w'(2);
    localparam logic [c_cnt_w-1:0]      c_cnt_one  = c_cnt_w'(1);
    localparam logic signed [ACC_W-1:0] c_pix_max  = ACC_W'((1 << PIX_W) - 1);
    localparam logic [3:0]              c_n_taps   = 4'd9;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_advance;
    logic w_accept;
    logic r_out_valid;

    assign w_advance = out_ready | ~r_out_valid;
    assign in_ready  = w_advance & ~rst;
    assign w_accept  = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Position counters. in_sof forces the current pixel to (0,0), so the
    // position used for this pixel is derived combinationally.
    // ------------------------------------------------------------------
    logic [c_cnt_w-1:0] r_col;
    logic [1:0]         r_row;      // saturates at 2: only row>=2 matters
    logic [c_cnt_w-1:0] r_ptr;      // line-buffer address, free-running
    logic [c_cnt_w-1:0] w_cur_col;
    logic [1:0]         w_cur_row;
    logic               w_col_wrap;
    logic               w_win_ok;

    always_comb begin
        w_cur_col  = in_sof ? '0 : r_col;
        w_cur_row  = in_sof ? 2'd0 : r_row;
        w_col_wrap = (w_cur_col == c_col_last);
        w_win_ok   = (w_cur_row == 2'd2) && (w_cur_col >= c_col_two);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= 2'd0;
            r_ptr <= '0;
        end else if (w_accept) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= (w_cur_row == 2'd2) ? 2'd2 : w_cur_row + 2'd1;
            end else begin
                r_col <= w_cur_col + c_cnt_one;
                r_row <= w_cur_row;
            end
            // The pointer ignores in_sof: each buffer must stay an exact
            // IMG_W-accept delay regardless of where a frame restarts.
            r_ptr <= (r_ptr == c_col_last) ? '0 : r_ptr + c_cnt_one;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers and window (data only, never reset)
    // Window is flattened row-major: index r*3+c, c=2 is the newest column.
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] r_lb1 [0:IMG_W-1];
    logic [PIX_W-1:0] r_lb2 [0:IMG_W-1];
    logic [PIX_W-1:0] r_win [0:8];
    logic [PIX_W-1:0] w_lb1_rd;
    logic [PIX_W-1:0] w_lb2_rd;

    assign w_lb1_rd = r_lb1[r_ptr];
    assign w_lb2_rd = r_lb2[r_ptr];

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb1[r_ptr] <= in_pix;
            r_lb2[r_ptr] <= w_lb1_rd;
            for (int r = 0; r < 3; r++) begin
                r_win[r*3]     <= r_win[r*3 + 1];
                r_win[r*3 + 1] <= r_win[r*3 + 2];
            end
            r_win[2] <= w_lb2_rd;
            r_win[5] <= w_lb1_rd;
            r_win[8] <= in_pix;
        end
    end

    // ------------------------------------------------------------------
    // Coefficients, identity kernel after reset
    // ------------------------------------------------------------------
    logic signed [COEF_W-1:0] r_coef [0:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                r_coef[k] <= (k == 4) ? COEF_W'(1) : '0;
            end
        end else if (coef_we && (coef_addr < c_n_taps)) begin
            r_coef[coef_addr] <= coef_data;
        end
    end

    // ------------------------------------------------------------------
    // S1 products: pixel zero-extended, coefficient sign-extended, both to
    // the full product width so the multiply is exact.
    // ------------------------------------------------------------------
    logic signed [c_prod_w-1:0] w_prod [0:8];
    logic signed [c_prod_w-1:0] r_prod [0:8];

    for (genvar k = 0; k < 9; k++) begin : g_tap
        logic signed [c_prod_w-1:0] w_pix_ext;
        logic signed [c_prod_w-1:0] w_coef_ext;
        assign w_pix_ext  = {{(COEF_W + 1){1'b0}}, r_win[k]};
        assign w_coef_ext = {{(PIX_W + 1){r_coef[k][COEF_W-1]}}, r_coef[k]};
        assign w_prod[k]  = w_pix_ext * w_coef_ext;
    end

    // ------------------------------------------------------------------
    // S2 adder tree and S3 shift/clamp
    // ------------------------------------------------------------------
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_shifted;
    logic [PIX_W-1:0]        w_clamped;

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < 9; k++) begin
            w_sum = w_sum + {{(ACC_W - c_prod_w){r_prod[k][c_prod_w-1]}}, r_prod[k]};
        end
    end

    always_comb begin
        w_shifted = r_acc >>> SHIFT;
        if (w_shifted[ACC_W-1]) begin
            w_clamped = '0;
        end else if (w_shifted > c_pix_max) begin
            w_clamped = '1;
        end else begin
            w_clamped = w_shifted[PIX_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (w_advance) begin
            for (int k = 0; k < 9; k++) begin
                r_prod[k] <= w_prod[k];
            end
            r_acc <= w_sum;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline valid bits and output registers. r_v0 flags that the window
    // register holds a fresh valid window not yet consumed by S1.
    // ------------------------------------------------------------------
    logic             r_v0;
    logic             r_v1;
    logic             r_v2;
    logic [ACC_W-1:0] r_out_raw;
    logic [PIX_W-1:0] r_out_pix;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v0        <= 1'b0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_raw   <= '0;
            r_out_pix   <= '0;
        end else if (w_advance) begin
            r_v0        <= w_accept & w_win_ok;
            r_v1        <= r_v0;
            r_v2        <= r_v1;
            r_out_valid <= r_v2;
            r_out_raw   <= w_shifted;
            r_out_pix   <= w_clamped;
        end
    end

    assign out_valid = r_out_valid;
    assign out_raw   = r_out_raw;
    assign out_pix   = r_out_pix;

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv3x3_stream
// Purpose  : Scoreboard bench for conv3x3_stream. Two instances (SHIFT=0 and
//            SHIFT=4, IMG_W=4) share one input stream; a frame-level model
//            computes every expected window result when a frame is issued,
//            and a negedge monitor pops and compares on each handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv3x3_stream;

    localparam int W  = 4;
    localparam int PW = 8;
    localparam int CW = 8;
    localparam int AW = PW + CW + 5;

    logic clk = 1'b0;
    logic rst;
    logic coef_we;
    logic [3:0] coef_addr;
    logic [CW-1:0] coef_data;
    logic in_valid;
    logic in_sof;
    logic [PW-1:0] in_pix;
    logic out_ready;
    logic rdy0, rdy1, ov0, ov1;
    logic signed [AW-1:0] raw0, raw1;
    logic [PW-1:0] pix0, pix1;

    conv3x3_stream #(.PIX_W(PW), .COEF_W(CW), .IMG_W(W), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .in_valid(in_valid), .in_ready(rdy0),
        .in_sof(in_sof), .in_pix(in_pix), .out_valid(ov0),
        .out_ready(out_ready), .out_raw(raw0), .out_pix(pix0));

    conv3x3_stream #(.PIX_W(PW), .COEF_W(CW), .IMG_W(W), .SHIFT(4)) dut1 (
        .clk(clk), .rst(rst), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .in_valid(in_valid), .in_ready(rdy1),
        .in_sof(in_sof), .in_pix(in_pix), .out_valid(ov1),
        .out_ready(out_ready), .out_raw(raw1), .out_pix(pix1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int raw0;
        int pix0;
        int raw1;
        int pix1;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   mcoef[9];
    int   frame[64];
    int   rdy_mode = 0;     // 0: always ready, 1: random, 2: held low
    bit   gaps = 1'b0;
    int   last_acc_cyc = 0;
    int   acc10_cyc = -1;
    int   first_ov_cyc = -1;

    int k_ident[9] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    int k_sharp[9] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};
    int k_ones[9]  = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    int k_blur[9]  = '{1, 2, 1, 2, 4, 2, 1, 2, 1};

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    function automatic int clampf(int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // Expected results of the first n raster pixels of frame[]: a window
    // centred at (r,c) exists once its bottom-right pixel has arrived.
    task automatic push_expect(input int n);
        exp_t e;
        int acc;
        for (int r = 1; r < 15; r++) begin
            for (int c = 1; c < W - 1; c++) begin
                if ((r + 1) * W + (c + 1) < n) begin
                    acc = 0;
                    for (int dr = 0; dr < 3; dr++)
                        for (int dc = 0; dc < 3; dc++)
                            acc += mcoef[dr*3 + dc] * frame[(r - 1 + dr) * W + (c - 1 + dc)];
                    e.raw0 = acc;
                    e.pix0 = clampf(acc);
                    e.raw1 = acc >>> 4;
                    e.pix1 = clampf(e.raw1);
                    sbq.push_back(e);
                end
            end
        end
    endtask

    // Output-ready driver
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor / scoreboard checker
    bit   stall = 1'b0;
    int   h_raw0, h_pix0, h_raw1, h_pix1;
    exp_t me;

    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (ov0 && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (ov0 || ov1) chk("valid_pair", int'(ov1), int'(ov0));
            if (stall) begin
                chk("hold_valid", int'(ov0), 1);
                chk("hold_raw0", int'(raw0), h_raw0);
                chk("hold_pix0", int'(pix0), h_pix0);
                chk("hold_raw1", int'(raw1), h_raw1);
                chk("hold_pix1", int'(pix1), h_pix1);
            end
            if (ov0 && out_ready) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got raw %0d expected no output", int'(raw0));
                end else begin
                    me = sbq.pop_front();
                    chk("raw0", int'(raw0), me.raw0);
                    chk("pix0", int'(pix0), me.pix0);
                    chk("raw1", int'(raw1), me.raw1);
                    chk("pix1", int'(pix1), me.pix1);
                end
            end
            stall  = ov0 && !out_ready;
            h_raw0 = int'(raw0);
            h_pix0 = int'(pix0);
            h_raw1 = int'(raw1);
            h_pix1 = int'(pix1);
        end
    end

    // Drivers. All tasks start and end at posedge+1.
    task automatic send_pix(input int pix, input bit sof);
        int t;
        if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_pix   = 8'(pix);
        in_sof   = sof;
        t = 0;
        @(negedge clk);
        while (!rdy0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!rdy0) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got in_ready 0 expected 1");
        end
        @(posedge clk);
        #1;
        last_acc_cyc = cyc;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int n);
        for (int i = 0; i < n; i++) begin
            send_pix(frame[i], i == 0);
            if (i == 10 && acc10_cyc < 0) acc10_cyc = last_acc_cyc;
        end
    endtask

    task automatic wr_coef(input int a, input int v);
        coef_we   = 1'b1;
        coef_addr = 4'(a);
        coef_data = 8'(v);
        @(posedge clk);
        #1;
        coef_we = 1'b0;
        if (a < 9) mcoef[a] = v;
    endtask

    task automatic load_kernel(input int k[9]);
        for (int i = 0; i < 9; i++) wr_coef(i, k[i]);
    endtask

    task automatic drain();
        int t = 0;
        while ((sbq.size() != 0 || ov0) && t < 1000) begin
            @(posedge clk);
            t++;
        end
        #1;
        chk("drain_empty", sbq.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        in_valid = 1'b0; in_sof = 1'b0; in_pix = '0; out_ready = 1'b1;
        for (int i = 0; i < 9; i++) mcoef[i] = k_ident[i];

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(rdy0), 0);
        rst = 1'b0;
        chk("rst_out_valid", int'(ov0), 0);
        chk("rst_out_raw", int'(raw0), 0);
        chk("rst_out_pix", int'(pix0), 0);
        chk("rst_out_raw1", int'(raw1), 0);

        // Identity kernel, frame 1..16, latency check
        for (int i = 0; i < 16; i++) frame[i] = i + 1;
        push_expect(16);
        send_frame(16);
        drain();
        chk("latency", first_ov_cyc - acc10_cyc, 3);

        // Sharpen, positive saturation
        load_kernel(k_sharp);
        frame[0:11] = '{2, 0, 0, 7, 5, 255, 0, 9, 1, 2, 4, 3};
        push_expect(12);
        send_frame(12);
        drain();

        // Sharpen, negative clamp
        for (int i = 0; i < 12; i++) frame[i] = 255;
        frame[5] = 0;
        push_expect(12);
        send_frame(12);
        drain();

        // Backpressure on 1..16 with sharpen
        rdy_mode = 1;
        for (int i = 0; i < 16; i++) frame[i] = i + 1;
        push_expect(16);
        send_frame(16);
        drain();
        rdy_mode = 0;

        // All-ones on constant 16, then immediate rewrite for next frame
        load_kernel(k_ones);
        for (int i = 0; i < 16; i++) frame[i] = 16;
        push_expect(16);
        send_frame(16);
        load_kernel(k_blur);
        push_expect(16);
        send_frame(16);
        drain();

        // Mid-frame in_sof after 6 pixels, then a full frame
        for (int i = 0; i < 6; i++) frame[i] = $urandom_range(0, 255);
        push_expect(6);
        send_frame(6);
        for (int i = 0; i < 16; i++) frame[i] = $urandom_range(0, 255);
        push_expect(16);
        send_frame(16);
        drain();

        // Mid-frame reset with results in flight
        for (int i = 0; i < 16; i++) frame[i] = $urandom_range(0, 255);
        push_expect(16);
        send_frame(12);
        rdy_mode = 2;
        repeat (4) @(posedge clk);
        #1;
        chk("inflight_valid", int'(ov0), 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_in_ready", int'(rdy0), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_out_valid", int'(ov0), 0);
        chk("rst_mid_out_raw", int'(raw0), 0);
        sbq.delete();
        for (int i = 0; i < 9; i++) mcoef[i] = k_ident[i];
        rdy_mode = 0;
        push_expect(16);
        send_frame(16);
        drain();

        // Randomized frames, kernels, gaps and backpressure
        rdy_mode = 1;
        gaps = 1'b1;
        for (int f = 0; f < 6; f++) begin
            int h;
            for (int i = 0; i < 9; i++) wr_coef(i, int'($urandom_range(0, 255)) - 128);
            wr_coef(9 + int'($urandom_range(0, 6)), int'($urandom_range(0, 255)) - 128);
            h = $urandom_range(3, 6);
            for (int i = 0; i < h * W; i++) frame[i] = $urandom_range(0, 255);
            push_expect(h * W);
            send_frame(h * W);
            drain();
        end
        rdy_mode = 0;
        gaps = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("final_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
